// File: rtl/toy_alu_dispatch.sv
// -----------------------------------------------------------------------------
// toy_pack / toy_alu_dispatch
//
// Purpose:
//   Issue-side buffer in front of the ALU execution port. Decoded instructions
//   with ready operands are queued in a small circular FIFO. The head entry is
//   presented to the ALU over an instruction_vld/instruction_rdy handshake.
//   When a control-flow instruction pops and the ALU reports a taken redirect,
//   all younger queued entries are dropped, flush pulses for that cycle, and
//   upstream beats are accepted and discarded for HOLD_CYCLES cycles. This
//   sinks fetches that were already in flight down the wrong path.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   in_vld / in_rdy          upstream handshake
//   in_pld, in_idx, in_rd_idx, in_rd_en, in_rs1_val, in_rs2_val, in_pc, in_imm
//                            upstream instruction payload
//   instruction_vld / instruction_rdy
//                            ALU handshake
//   instruction_pld, instruction_idx, inst_rd_idx, inst_rd_en, rs1_val,
//   rs2_val, pc, inst_imm    payload presented to the ALU
//   pc_release_en            ALU: control-flow instruction resolved
//   pc_update_en             ALU: redirect taken
//   flush                    one-cycle pulse in the cycle a redirect is taken
//   busy                     queue non-empty or redirect hold window active
//
// Optional feature:
//   TOY_ALU_DISPATCH_BYPASS_EN - when the queue is empty and the block is not
//   holding, the upstream beat goes straight to the ALU in the same cycle. If
//   the ALU accepts it, the beat is not written to the queue.
// -----------------------------------------------------------------------------

package toy_pack;
    localparam int INST_WIDTH     = 32;
    localparam int INST_IDX_WIDTH = 6;
    localparam int REG_WIDTH      = 32;
    localparam int ADDR_WIDTH     = 32;
endpackage

module toy_alu_dispatch
    import toy_pack::*;
#(
    parameter int DEPTH       = 4,
    parameter int HOLD_CYCLES = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_vld,
    output logic                      in_rdy,
    input  logic [INST_WIDTH-1:0]     in_pld,
    input  logic [INST_IDX_WIDTH-1:0] in_idx,
    input  logic [4:0]                in_rd_idx,
    input  logic                      in_rd_en,
    input  logic [REG_WIDTH-1:0]      in_rs1_val,
    input  logic [REG_WIDTH-1:0]      in_rs2_val,
    input  logic [ADDR_WIDTH-1:0]     in_pc,
    input  logic [31:0]               in_imm,
    output logic                      instruction_vld,
    input  logic                      instruction_rdy,
    output logic [INST_WIDTH-1:0]     instruction_pld,
    output logic [INST_IDX_WIDTH-1:0] instruction_idx,
    output logic [4:0]                inst_rd_idx,
    output logic                      inst_rd_en,
    output logic [REG_WIDTH-1:0]      rs1_val,
    output logic [REG_WIDTH-1:0]      rs2_val,
    output logic [ADDR_WIDTH-1:0]     pc,
    output logic [31:0]               inst_imm,
    input  logic                      pc_release_en,
    input  logic                      pc_update_en,
    output logic                      flush,
    output logic                      busy
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int HC_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_BRANCH = 5'b11000;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    typedef struct packed {
        logic [INST_WIDTH-1:0]     pld;
        logic [INST_IDX_WIDTH-1:0] idx;
        logic [4:0]                rd_idx;
        logic                      rd_en;
        logic [REG_WIDTH-1:0]      rs1;
        logic [REG_WIDTH-1:0]      rs2;
        logic [ADDR_WIDTH-1:0]     pc;
        logic [31:0]               imm;
    } entry_t;

    state_t            state_q, state_d;
    logic [HC_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    entry_t            mem_q [DEPTH];
    entry_t            mem_d [DEPTH];

    entry_t            in_entry;
    entry_t            out_entry;
    logic              run;
    logic              q_empty;
    logic              byp_sel;
    logic              pop;
    logic              q_pop;
    logic              byp_pop;
    logic              is_cf;
    logic              taken;
    logic              push;

    // A not-taken resolve is an ordinary pop, so release alone drives nothing.
    logic              unused_release;
    assign unused_release = pc_release_en;

    assign in_entry = '{pld: in_pld, idx: in_idx, rd_idx: in_rd_idx,
                        rd_en: in_rd_en, rs1: in_rs1_val, rs2: in_rs2_val,
                        pc: in_pc, imm: in_imm};

    assign run     = (state_q == ST_RUN);
    assign q_empty = (count_q == '0);

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state: the hold window lasts HOLD_CYCLES cycles after the
    // taken cycle, whatever upstream does during it.
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            ST_RUN: begin
                if (taken) begin
                    state_d    = ST_HOLD;
                    hold_cnt_d = HC_W'(HOLD_CYCLES - 1);
                end
            end
            ST_HOLD: begin
                if (hold_cnt_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    hold_cnt_d = hold_cnt_q - HC_W'(1);
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM outputs: handshake, payload selection, flush and busy
    // ------------------------------------------------------------------
    always_comb begin
        byp_sel = 1'b0;
`ifdef TOY_ALU_DISPATCH_BYPASS_EN
        byp_sel = q_empty && run;
`endif
        out_entry       = byp_sel ? in_entry : mem_q[rd_ptr_q];
        instruction_vld = byp_sel ? in_vld : (!q_empty && run);
        // In HOLD everything is sunk, so upstream is never stalled there.
        in_rdy          = run ? (count_q < CNT_W'(DEPTH)) : 1'b1;
        busy            = !q_empty || !run;
    end

    assign instruction_pld = out_entry.pld;
    assign instruction_idx = out_entry.idx;
    assign inst_rd_idx     = out_entry.rd_idx;
    assign inst_rd_en      = out_entry.rd_en;
    assign rs1_val         = out_entry.rs1;
    assign rs2_val         = out_entry.rs2;
    assign pc              = out_entry.pc;
    assign inst_imm        = out_entry.imm;

    assign is_cf = (out_entry.pld[6:2] == OP_JAL)  ||
                   (out_entry.pld[6:2] == OP_JALR) ||
                   (out_entry.pld[6:2] == OP_BRANCH);

    assign pop     = instruction_vld && instruction_rdy;
    assign byp_pop = pop && byp_sel;
    assign q_pop   = pop && !byp_sel;
    // ALU resolve signals only matter when a control-flow head leaves.
    assign taken   = pop && is_cf && pc_update_en;
    assign flush   = taken;
    // A push in the taken cycle would be a wrong-path fetch, so it is dropped.
    assign push    = in_vld && in_rdy && run && !taken && !byp_pop;

    // ------------------------------------------------------------------
    // Queue pointers, occupancy and entry storage
    // ------------------------------------------------------------------
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end

        if (taken) begin
            // Drop everything younger than the redirecting instruction. A
            // bypassed redirect never occupied the queue, so its pointers
            // are already equal and stay where they are.
            if (q_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
                wr_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = in_entry;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (q_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(q_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

endmodule
